// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC sequencer: RUN/WAIT/HALT control with push-button resume (optional BUTTON_DEBOUNCE_EN)
`timescale 1ns/1ps

module pc_sequencer #(
  parameter int program_code_size = 8,
  parameter int debounce_cycles   = 4
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic [program_code_size-1:0] pc_in,
  input  logic                         is_halt,
  input  logic                         is_wait,
  input  logic                         is_branch,
  input  logic                         zero_flag,
  input  logic [program_code_size-1:0] branch_offset,
  input  logic                         button,
  output logic                         pc_inc,
  output logic                         pc_load,
  output logic [program_code_size-1:0] pc_target,
  output logic                         waiting,
  output logic                         halted
);

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    HALT         = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic sync_meta;
  logic sync_out;
  logic btn_s;

  // A zero or negative filter length would make the debounce counter meaningless
  if (debounce_cycles < 1) begin : g_bad_debounce_cfg
    $error("pc_sequencer: debounce_cycles must be at least 1");
  end

  // Two-flop synchronizer bringing the asynchronous button into the clk domain
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= button;
      sync_out  <= sync_meta;
    end
  end

`ifdef BUTTON_DEBOUNCE_EN
  localparam int CNT_W = $clog2(debounce_cycles + 1);

  logic [CNT_W-1:0] db_cnt;
  logic             db_level;

  // Accept a new button level only after it has differed from the filtered level for debounce_cycles cycles in a row
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (sync_out == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_W'(debounce_cycles - 1)) begin
      db_level <= sync_out;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign btn_s = db_level;
`else
  assign btn_s = sync_out;
`endif

  // Relative branch target wraps modulo the address width in both directions
  assign pc_target = pc_in + branch_offset;

  assign waiting = (state == WAIT_PRESS) || (state == WAIT_RELEASE);
  assign halted  = (state == HALT);

  // State register; reset always lands in RUN regardless of where the sequencer was
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and PC request decode; decoder flags only matter in RUN
  always_comb begin
    state_next = state;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    case (state)
      RUN: begin
        if (is_halt) begin
          state_next = HALT;
        end else if (is_wait) begin
          state_next = WAIT_PRESS;
        end else if (is_branch && zero_flag) begin
          pc_load = 1'b1;
        end else begin
          pc_inc = 1'b1;
        end
      end
      WAIT_PRESS: begin
        if (btn_s) begin
          state_next = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!btn_s) begin
          pc_inc     = 1'b1;
          state_next = RUN;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
`timescale 1ns/1ps

module tb_pc_sequencer;

  localparam int W = 8;
`ifdef BUTTON_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         n_reset;
  logic [W-1:0] pc_in;
  logic         is_halt;
  logic         is_wait;
  logic         is_branch;
  logic         zero_flag;
  logic [W-1:0] branch_offset;
  logic         button;
  logic         pc_inc;
  logic         pc_load;
  logic [W-1:0] pc_target;
  logic         waiting;
  logic         halted;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(
    .program_code_size(W),
    .debounce_cycles(4)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .pc_in(pc_in),
    .is_halt(is_halt),
    .is_wait(is_wait),
    .is_branch(is_branch),
    .zero_flag(zero_flag),
    .branch_offset(branch_offset),
    .button(button),
    .pc_inc(pc_inc),
    .pc_load(pc_load),
    .pc_target(pc_target),
    .waiting(waiting),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] v_pc  [4] = '{8'h02, 8'h02, 8'hF0, 8'h7F};
  logic [W-1:0] v_off [4] = '{8'hFC, 8'hFC, 8'h20, 8'h01};
  logic         v_br  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic         v_zf  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] v_tgt [4] = '{8'hFE, 8'hFE, 8'h10, 8'h80};
  logic         v_inc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic         v_ld  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    n_reset       = 1'b0;
    pc_in         = 8'h10;
    is_halt       = 1'b0;
    is_wait       = 1'b0;
    is_branch     = 1'b0;
    zero_flag     = 1'b0;
    branch_offset = 8'h00;
    button        = 1'b0;

    #2;
    chk("reset_waiting", waiting, 0);
    chk("reset_halted", halted, 0);
    chk("reset_pc_inc", pc_inc, 1);
    chk("reset_pc_load", pc_load, 0);
    repeat (2) @(posedge clk);
    #2 n_reset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      drive_point();
      @(negedge clk);
      chk("run_plain_pc_inc", pc_inc, 1);
      chk("run_plain_pc_load", pc_load, 0);
    end

    for (int i = 0; i < 4; i++) begin
      drive_point();
      pc_in         = v_pc[i];
      branch_offset = v_off[i];
      is_branch     = v_br[i];
      zero_flag     = v_zf[i];
      @(negedge clk);
      chk("branch_target", pc_target, v_tgt[i]);
      chk("branch_pc_inc", pc_inc, v_inc[i]);
      chk("branch_pc_load", pc_load, v_ld[i]);
    end

    drive_point();
    is_wait   = 1'b1;
    is_branch = 1'b1;
    zero_flag = 1'b1;
    @(negedge clk);
    chk("wait_prio_pc_inc", pc_inc, 0);
    chk("wait_prio_pc_load", pc_load, 0);
    chk("wait_prio_waiting", waiting, 0);
    drive_point();
    is_wait = 1'b0;
    button  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("wait_press_waiting", waiting, 1);
      chk("wait_press_pc_inc", pc_inc, 0);
      chk("wait_press_pc_load", pc_load, 0);
      drive_point();
    end
    button = 1'b0;
    for (int j = 0; j <= LAT + 1; j++) begin
      @(negedge clk);
      chk("release_pc_inc", pc_inc, (j == LAT) ? 1 : 0);
      chk("release_pc_load", pc_load, (j > LAT) ? 1 : 0);
      chk("release_waiting", waiting, (j <= LAT) ? 1 : 0);
      drive_point();
    end
    is_branch = 1'b0;
    zero_flag = 1'b0;

`ifdef BUTTON_DEBOUNCE_EN
    is_wait = 1'b1;
    drive_point();
    is_wait = 1'b0;
    button  = 1'b1;
    drive_point();
    drive_point();
    button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("glitch_waiting", waiting, 1);
      chk("glitch_pc_inc", pc_inc, 0);
      drive_point();
    end
    n_reset = 1'b0;
    #1 n_reset = 1'b1;
`endif

    drive_point();
    is_wait = 1'b1;
    drive_point();
    is_wait = 1'b0;
    button  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("held_waiting", waiting, 1);
      chk("held_pc_inc", pc_inc, 0);
    end
    #2 n_reset = 1'b0;
    #1;
    chk("rst_wait_waiting", waiting, 0);
    chk("rst_wait_pc_inc", pc_inc, 1);
    is_branch = 1'b1;
    zero_flag = 1'b1;
    #1;
    chk("rst_wait_pc_load", pc_load, 1);
    n_reset = 1'b1;
    drive_point();
    button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_pc_inc", pc_inc, 0);
      chk("post_rst_pc_load", pc_load, 1);
      chk("post_rst_waiting", waiting, 0);
      drive_point();
    end
    is_branch = 1'b0;
    zero_flag = 1'b0;

    is_halt = 1'b1;
    is_wait = 1'b1;
    @(negedge clk);
    chk("halt_prio_pc_inc", pc_inc, 0);
    chk("halt_prio_pc_load", pc_load, 0);
    chk("halt_prio_halted", halted, 0);
    for (int i = 0; i < 20; i++) begin
      drive_point();
      button    = i[0];
      is_wait   = i[1];
      is_branch = i[2];
      is_halt   = i[3];
      zero_flag = 1'b1;
      @(negedge clk);
      chk("halt_halted", halted, 1);
      chk("halt_waiting", waiting, 0);
      chk("halt_pc_inc", pc_inc, 0);
      chk("halt_pc_load", pc_load, 0);
    end
    drive_point();
    button    = 1'b0;
    is_wait   = 1'b0;
    is_branch = 1'b0;
    is_halt   = 1'b0;
    zero_flag = 1'b0;
    #2 n_reset = 1'b0;
    #0.5;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_pc_inc", pc_inc, 1);
    #0.5 n_reset = 1'b1;
    @(negedge clk);
    chk("after_halt_halted", halted, 0);
    chk("after_halt_pc_inc", pc_inc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
